// File: rtl/store_order_tracker_if.sv
// Bus bundle for store_order_tracker: per-channel store issue/retire handshakes,
// fence control and status. The tracker connects through the slave modport.
interface store_order_tracker_if #(
  parameter int NR_CHANNELS     = 2,
  parameter int MAX_OUTSTANDING = 7,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
  parameter int CHAN_W          = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
);
  logic [NR_CHANNELS-1:0]       st_valid_i;
  logic [NR_CHANNELS-1:0]       st_ready_o;
  logic [NR_CHANNELS-1:0]       st_ack_i;
  logic                         fence_req_i;
  logic                         fence_single_i;
  logic [CHAN_W-1:0]            fence_chan_i;
  logic                         fence_busy_o;
  logic                         fence_ack_o;
  logic [NR_CHANNELS*CNT_W-1:0] outstanding_o;
  logic                         all_idle_o;
  logic                         err_o;
  logic                         fence_timeout_o;

  modport master (
    output st_valid_i, st_ack_i, fence_req_i, fence_single_i, fence_chan_i,
    input  st_ready_o, fence_busy_o, fence_ack_o, outstanding_o, all_idle_o,
           err_o, fence_timeout_o
  );

  modport slave (
    input  st_valid_i, st_ack_i, fence_req_i, fence_single_i, fence_chan_i,
    output st_ready_o, fence_busy_o, fence_ack_o, outstanding_o, all_idle_o,
           err_o, fence_timeout_o
  );
endinterface

// File: rtl/store_order_tracker.sv
// Per-channel outstanding-store tracker with a global/single-channel fence drain FSM.
// Optional drain watchdog enabled by defining STORE_ORDER_TRACKER_TIMEOUT_EN.
module store_order_tracker #(
  parameter int NR_CHANNELS     = 2,
  parameter int MAX_OUTSTANDING = 7,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  store_order_tracker_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  logic [CNT_W-1:0]             cnt_q [NR_CHANNELS];
  logic [CNT_W-1:0]             cnt_d [NR_CHANNELS];
  logic [1:0]                   state_q, state_d;
  logic [NR_CHANNELS-1:0]       target_q, target_d;
  logic                         err_q, err_d;
  logic [NR_CHANNELS-1:0]       blocked, ready, issue, cntZero, nextZero, selMask, newTarget;
  logic [NR_CHANNELS*CNT_W-1:0] outstanding;
  logic                         targetsEmpty;
  logic                         timeoutHit;

  // Ready looks only at registered state, so a same-cycle ack never reopens a full channel.
  always_comb begin
    blocked = (state_q == DRAIN) ? target_q : '0;
    err_d   = err_q;
    for (int i = 0; i < NR_CHANNELS; i++) begin
      ready[i] = (cnt_q[i] != MaxCnt) && !blocked[i];
      issue[i] = bus.st_valid_i[i] && ready[i];
      cnt_d[i] = cnt_q[i];
      if (issue[i] && !bus.st_ack_i[i]) begin
        cnt_d[i] = cnt_q[i] + OneCnt;
      end else if (bus.st_ack_i[i] && !issue[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - OneCnt;
      end
      if (bus.st_ack_i[i] && (cnt_q[i] == '0)) begin
        err_d = 1'b1;
      end
      cntZero[i]  = (cnt_q[i] == '0);
      nextZero[i] = (cnt_d[i] == '0);
      selMask[i]  = (int'(bus.fence_chan_i) == i);
      outstanding[i*CNT_W +: CNT_W] = cnt_q[i];
    end
    targetsEmpty = &(nextZero | ~target_q);
    newTarget    = (bus.fence_single_i && (int'(bus.fence_chan_i) < NR_CHANNELS)) ? selMask : '1;
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        if (bus.fence_req_i) begin
          target_d = newTarget;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (targetsEmpty || timeoutHit) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      target_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NR_CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef STORE_ORDER_TRACKER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic              timeout_q, timeout_d;

  // The wait counter idles at zero, so every entry into DRAIN starts a fresh count.
  assign timeoutHit = (state_q == DRAIN) && (waitCnt_q == WaitLast);

  always_comb begin
    waitCnt_d = (state_q == DRAIN) ? (waitCnt_q + WAIT_W'(1)) : '0;
    timeout_d = timeout_q | (timeoutHit && !targetsEmpty);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      waitCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      waitCnt_q <= waitCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.fence_timeout_o = timeout_q;
`else
  assign timeoutHit = 1'b0;
  // Constant 0; the comparison keeps the watchdog limit referenced when no watchdog exists.
  assign bus.fence_timeout_o = (TIMEOUT_CYCLES < 0);
`endif

  assign bus.st_ready_o    = ready;
  assign bus.fence_busy_o  = (state_q != IDLE);
  assign bus.fence_ack_o   = (state_q == DONE);
  assign bus.outstanding_o = outstanding;
  assign bus.all_idle_o    = &cntZero;
  assign bus.err_o         = err_q;
endmodule

// File: tb/tb_store_order_tracker.sv
// Scoreboard bench for store_order_tracker: directed stimulus queues expected state
// and fence-ack cycles; a negedge monitor pops and compares.
module tb_store_order_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   tmo = 0;
  int   t0 = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  c0;
    logic [7:0]  c1;
    logic [1:0]  ready;
    logic        busy;
    logic        idle;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t  expQ[$];
  string tagQ[$];
  int    ackQ[$];
  exp_t  e;
  string t;

  store_order_tracker_if #(.NR_CHANNELS(2), .MAX_OUTSTANDING(7)) bus ();

  store_order_tracker #(
    .NR_CHANNELS(2), .MAX_OUTSTANDING(7), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input string field, input int actual,
                             input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s.%s cycle %0d: got %0d, expected %0d", tag, field, cyc, actual,
               expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] ack,
                               input logic freq, input logic single, input logic chan);
    @(posedge clk);
    #1;
    bus.st_valid_i     = valid;
    bus.st_ack_i       = ack;
    bus.fence_req_i    = freq;
    bus.fence_single_i = single;
    bus.fence_chan_i   = chan;
  endtask

  task automatic expectState(input string tag, input int c0, input int c1,
                             input logic [1:0] ready, input logic busy, input logic err,
                             input int tm);
    exp_t x;
    x.cyc   = cyc;
    x.c0    = 8'(c0);
    x.c1    = 8'(c1);
    x.ready = ready;
    x.busy  = busy;
    x.idle  = (c0 == 0) && (c1 == 0);
    x.err   = err;
    x.tmo   = (tm != 0);
    expQ.push_back(x);
    tagQ.push_back(tag);
  endtask

  // Monitor: compares queued state expectations and every fence_ack pulse.
  always @(negedge clk) begin
    while (expQ.size() > 0 && int'(expQ[0].cyc) <= cyc) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      if (int'(e.cyc) != cyc) begin
        checkOutput(t, "sampleCycle", cyc, int'(e.cyc));
      end else begin
        checkOutput(t, "ch0", int'(bus.outstanding_o[2:0]), int'(e.c0));
        checkOutput(t, "ch1", int'(bus.outstanding_o[5:3]), int'(e.c1));
        checkOutput(t, "ready", int'(bus.st_ready_o), int'(e.ready));
        checkOutput(t, "busy", int'(bus.fence_busy_o), int'(e.busy));
        checkOutput(t, "allIdle", int'(bus.all_idle_o), int'(e.idle));
        checkOutput(t, "err", int'(bus.err_o), int'(e.err));
        checkOutput(t, "timeout", int'(bus.fence_timeout_o), int'(e.tmo));
      end
    end
    if (ackQ.size() > 0 && ackQ[0] < cyc) begin
      checkOutput("fenceAck", "missingAtCycle", cyc, ackQ.pop_front());
    end
    if (bus.fence_ack_o === 1'b1) begin
      if (ackQ.size() > 0 && ackQ[0] == cyc) begin
        checkOutput("fenceAck", "pulseCycle", cyc, ackQ.pop_front());
      end else begin
        checkOutput("fenceAck", "unexpectedAtCycle", cyc, -1);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $finish;
  end

  initial begin
    bus.st_valid_i     = '0;
    bus.st_ack_i       = '0;
    bus.fence_req_i    = 1'b0;
    bus.fence_single_i = 1'b0;
    bus.fence_chan_i   = 1'b0;

    repeat (2) applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("reset", 0, 0, 2'b11, 0, 0, 0);
    rst = 1'b0;

    // Fill channel 0 to its limit, then retire one store.
    repeat (7) applyStimulus(2'b01, 2'b00, 0, 0, 0);
    applyStimulus(2'b01, 2'b00, 0, 0, 0);
    expectState("full", 7, 0, 2'b10, 0, 0, 0);
    applyStimulus(2'b00, 2'b01, 0, 0, 0);
    expectState("ackNoReady", 7, 0, 2'b10, 0, 0, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("readyBack", 6, 0, 2'b11, 0, 0, 0);

    // Simultaneous issue and ack keep the count.
    repeat (3) applyStimulus(2'b00, 2'b01, 0, 0, 0);
    applyStimulus(2'b01, 2'b01, 0, 0, 0);
    expectState("issueAck", 3, 0, 2'b11, 0, 0, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("sameCount", 3, 0, 2'b11, 0, 0, 0);
    repeat (3) applyStimulus(2'b00, 2'b01, 0, 0, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("drained", 0, 0, 2'b11, 0, 0, 0);

    // Ack with nothing outstanding.
    applyStimulus(2'b00, 2'b10, 0, 0, 0);
    expectState("ackZeroPre", 0, 0, 2'b11, 0, 0, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("errSet", 0, 0, 2'b11, 0, 1, 0);
    repeat (3) applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("errSticky", 0, 0, 2'b11, 0, 1, 0);

    // Global fence: ch0=2, ch1=1, acks at T+3, T+4, T+6.
    applyStimulus(2'b11, 2'b00, 0, 0, 0);
    applyStimulus(2'b01, 2'b00, 0, 0, 0);
    applyStimulus(2'b00, 2'b00, 1, 0, 0);
    t0 = cyc;
    expectState("gReq", 2, 1, 2'b11, 0, 1, 0);
    ackQ.push_back(t0 + 7);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("gDrain", 2, 1, 2'b00, 1, 1, 0);
    applyStimulus(2'b11, 2'b00, 0, 0, 0);
    applyStimulus(2'b00, 2'b01, 0, 0, 0);
    expectState("gBlocked", 2, 1, 2'b00, 1, 1, 0);
    applyStimulus(2'b00, 2'b10, 0, 0, 0);
    expectState("gAck2", 1, 1, 2'b00, 1, 1, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("gWait", 1, 0, 2'b00, 1, 1, 0);
    applyStimulus(2'b00, 2'b01, 0, 0, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("gDone", 0, 0, 2'b11, 1, 1, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("gIdle", 0, 0, 2'b11, 0, 1, 0);

    // Single fence on ch1 while ch0 keeps issuing; held request is ignored.
    repeat (4) applyStimulus(2'b01, 2'b00, 0, 0, 0);
    applyStimulus(2'b00, 2'b00, 1, 1, 1);
    t0 = cyc;
    expectState("sReq", 4, 0, 2'b11, 0, 1, 0);
    ackQ.push_back(t0 + 2);
    applyStimulus(2'b01, 2'b00, 1, 1, 1);
    expectState("sDrain", 4, 0, 2'b01, 1, 1, 0);
    applyStimulus(2'b01, 2'b00, 0, 0, 0);
    expectState("sDone", 5, 0, 2'b11, 1, 1, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("sNoSecond", 6, 0, 2'b11, 0, 1, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    applyStimulus(2'b00, 2'b00, 1, 1, 1);
    t0 = cyc;
    ackQ.push_back(t0 + 2);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("sReissue", 6, 0, 2'b01, 1, 1, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("sIdle", 6, 0, 2'b11, 0, 1, 0);

    // Fence with ch0=1 and no acks: watchdog fires, or drain waits indefinitely.
    repeat (5) applyStimulus(2'b00, 2'b01, 0, 0, 0);
    applyStimulus(2'b00, 2'b00, 1, 0, 0);
    t0 = cyc;
    expectState("wReq", 1, 0, 2'b11, 0, 1, 0);
`ifdef STORE_ORDER_TRACKER_TIMEOUT_EN
    ackQ.push_back(t0 + 17);
    repeat (16) applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("wLastDrain", 1, 0, 2'b00, 1, 1, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    tmo = 1;
    expectState("wTimeout", 1, 0, 2'b11, 1, 1, tmo);
    applyStimulus(2'b00, 2'b01, 0, 0, 0);
    expectState("wAfter", 1, 0, 2'b11, 0, 1, tmo);
`else
    repeat (20) applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("wStillDrain", 1, 0, 2'b00, 1, 1, 0);
    applyStimulus(2'b00, 2'b01, 0, 0, 0);
    ackQ.push_back(t0 + 22);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("wDone", 0, 0, 2'b11, 1, 1, 0);
`endif
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("wIdle", 0, 0, 2'b11, 0, 1, tmo);

    // Reset in the middle of a drain: no ack, everything cleared.
    applyStimulus(2'b01, 2'b00, 0, 0, 0);
    applyStimulus(2'b00, 2'b00, 1, 0, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("rDrain", 1, 0, 2'b00, 1, 1, tmo);
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("rReset", 0, 0, 2'b11, 0, 0, 0);
    rst = 1'b0;
    applyStimulus(2'b00, 2'b01, 0, 0, 0);
    expectState("rStrayAck", 0, 0, 2'b11, 0, 0, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    expectState("rStrayErr", 0, 0, 2'b11, 0, 1, 0);
    repeat (3) applyStimulus(2'b00, 2'b00, 0, 0, 0);

    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkOutput(t, "unchecked", cyc, int'(e.cyc));
    end
    while (ackQ.size() > 0) begin
      checkOutput("fenceAck", "neverSeen", cyc, ackQ.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/store_order_tracker.md
Name: store_order_tracker

Overview:
Parametrised per-channel outstanding-store tracker and fence drain unit for the RVWMO write-through data cache path. It generalises the fixed single-limit store budget (7 stores, 8-entry write buffer) to N store channels, each with its own budget. It adds a fence FSM that supports either a global drain or a single-channel drain. It sits between the store unit issue ports and the write-buffer acknowledge path, and gates store issue and fence completion.

Parameters:
NR_CHANNELS, 2, number of independent store channels (1..8)
MAX_OUTSTANDING, 7, per-channel outstanding-store limit (1..255)
CNT_W, $clog2(MAX_OUTSTANDING+1), counter width (derived, do not override)
TIMEOUT_CYCLES, 1024, drain watchdog limit; used only with the optional feature

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
st_valid_i  in  NR_CHANNELS  store issue request, one bit per channel
st_ready_o  out  NR_CHANNELS  store issue accepted when valid&ready
st_ack_i  in  NR_CHANNELS  store retired by write buffer/memory (1-cycle pulse)
fence_req_i  in  1  fence request, sampled in IDLE only
fence_single_i  in  1  0 = drain all channels, 1 = drain only fence_chan_i
fence_chan_i  in  $clog2(NR_CHANNELS) (min 1)  channel selected for single drain
fence_busy_o  out  1  FSM not in IDLE
fence_ack_o  out  1  1-cycle pulse: fence complete
outstanding_o  out  NR_CHANNELS*CNT_W  packed per-channel counts; channel 0 in the LSBs
all_idle_o  out  1  all counters zero
err_o  out  1  sticky: ack received with count 0
fence_timeout_o  out  1  sticky watchdog flag; tied 0 without the optional feature

Behaviour:
- Reset values: all counters 0; FSM IDLE; st_ready_o all 1; fence_busy_o 0; fence_ack_o 0; all_idle_o 1; err_o 0; fence_timeout_o 0.
- Per-channel counter c, updated each cycle:
  - issue = st_valid_i & st_ready_o; ack = st_ack_i.
  - issue & !ack: c+1. ack & !issue: c-1. Both or neither: c unchanged.
- st_ready_o[i] is combinational and equals (c[i] != MAX_OUTSTANDING) and not blocked[i].
  - Simultaneous ack does not raise ready in the same cycle, so ready depends only on registered state.
- Ack on a channel whose count is 0:
  - counter stays 0 (no wrap);
  - err_o set, cleared only by reset.
- Fence FSM states: IDLE, DRAIN, DONE.
- IDLE:
  - fence_req_i=1: latch fence_single_i and fence_chan_i, go to DRAIN.
- DRAIN:
  - blocked[i]=1 for every target channel (all channels, or only the latched channel). Non-target channels keep issuing.
  - Acks keep decrementing.
  - All target counters zero, evaluated on the registered count after the current cycle's update: go to DONE.
- DONE:
  - fence_ack_o=1 for exactly one cycle, blocked cleared, go to IDLE.
- Latency with targets already empty at request: req in cycle T, DRAIN in T+1, ack pulse in T+2.
- fence_req_i outside IDLE is ignored. The requester holds or reissues after fence_busy_o falls.
- fence_busy_o=1 in DRAIN and DONE.
- fence_chan_i >= NR_CHANNELS in single mode: treated as a global drain.
- all_idle_o is combinational: AND of (c[i]==0) over all channels.
- Reset asserted mid-drain: FSM returns to IDLE, no ack pulse, counters cleared. In-flight acks after reset hit count 0 and set err_o; integration must reset the write buffer together with this block.

Optional Feature:
- Macro: STORE_ORDER_TRACKER_TIMEOUT_EN.
- Defined:
  - a wait counter clears on entry to DRAIN and increments each DRAIN cycle.
  - When the counter reaches TIMEOUT_CYCLES: fence_timeout_o is set sticky, and the FSM forces DONE (ack pulse) to avoid deadlock. Counters are not modified.
- Undefined: no watchdog logic is built; fence_timeout_o is tied 0; DRAIN waits indefinitely.

Test Plan:
- Reset, then 7 issues on ch0 with no acks -> outstanding ch0=7, st_ready_o[0]=0, ch1 ready=1; one ack -> count 6, ready returns next cycle.
- ch0 count 3, issue and ack in the same cycle -> count stays 3, err_o=0.
- Ack on ch1 with count 0 -> count stays 0, err_o=1 and remains 1 until rst_i.
- Global fence with ch0=2, ch1=1; acks in cycles T+3, T+4, T+6 -> st_ready_o=00 during DRAIN, fence_ack_o pulses once at T+7, then ready=11.
- Single fence on ch1 with ch0=4, ch1=0 -> ch0 keeps issuing, ack at T+2; a fence_req held during DRAIN of a prior fence produces no second ack until reissued.
- With STORE_ORDER_TRACKER_TIMEOUT_EN and TIMEOUT_CYCLES=16: fence with ch0=1 and no acks -> fence_timeout_o=1 and fence_ack_o pulses after 16 DRAIN cycles, count still 1.
